// File: rtl/ofs_pcie_ss_cfg_pkg.sv
// Default bus geometry for the PCIe subsystem AXI-Stream interfaces.
package ofs_pcie_ss_cfg_pkg;
    localparam int TDATA_WIDTH = 512;
    localparam int TUSER_WIDTH = 10;
endpackage

// File: rtl/pcie_ss_axis_demux.sv
// Packet-atomic AXI-Stream 1:N demux, routes whole packets by first-beat tdest; 1-cycle latency.
// Single shared output register; a stalled destination back-pressures the input (head-of-line).
module pcie_ss_axis_demux #(
    parameter int NUM_CH      = 2,
    parameter int TDATA_WIDTH = ofs_pcie_ss_cfg_pkg::TDATA_WIDTH,
    parameter int TUSER_WIDTH = ofs_pcie_ss_cfg_pkg::TUSER_WIDTH,
    localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int TKEEP_W    = TDATA_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic [TDATA_WIDTH-1:0] s_tdata,
    input  logic [TKEEP_W-1:0]     s_tkeep,
    input  logic                   s_tlast,
    input  logic [TUSER_WIDTH-1:0] s_tuser_vendor,
    input  logic [SEL_W-1:0]       s_tdest,

    output logic [NUM_CH-1:0]      m_tvalid,
    input  logic [NUM_CH-1:0]      m_tready,
    output logic [TDATA_WIDTH-1:0] m_tdata,
    output logic [TKEEP_W-1:0]     m_tkeep,
    output logic                   m_tlast,
    output logic [TUSER_WIDTH-1:0] m_tuser_vendor,

    output logic [15:0]            drop_cnt,
    output logic                   drop_pulse
);

    typedef enum logic {SOP, MID} state_t;

    localparam logic [SEL_W:0] NUM_CH_V = (SEL_W + 1)'(NUM_CH);

    state_t            state;
    logic [SEL_W-1:0]  dest_q;
    logic              drop_q;

    logic              sop_bad;
    logic              drop_active;
    logic [SEL_W-1:0]  cur_dest;
    logic [NUM_CH-1:0] cur_onehot;
    logic              pop;
    logic              accept;
    logic              load;

    always_comb begin
        sop_bad     = ({1'b0, s_tdest} >= NUM_CH_V);
        drop_active = (state == SOP) ? sop_bad : drop_q;
        cur_dest    = (state == SOP) ? s_tdest : dest_q;
        cur_onehot  = NUM_CH'(1) << cur_dest;
        // m_tvalid is one-hot, so this is out_valid & m_tready[out_dest]
        pop         = |(m_tvalid & m_tready);
        s_tready    = ~rst & (drop_active | ~(|m_tvalid) | pop);
        accept      = s_tvalid & s_tready;
        load        = accept & ~drop_active;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SOP;
            dest_q     <= '0;
            drop_q     <= 1'b0;
            m_tvalid   <= '0;
            drop_cnt   <= '0;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= accept & (state == SOP) & sop_bad;

            if (accept) begin
                if (state == SOP) begin
                    dest_q <= s_tdest;
                    drop_q <= sop_bad;
                end
                state <= s_tlast ? SOP : MID;
            end

            if (load) begin
                m_tvalid <= cur_onehot;
            end else if (pop) begin
                m_tvalid <= '0;
            end

            if (accept && (state == SOP) && sop_bad && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // Payload carries no reset: it is only meaningful while a m_tvalid bit is set.
    always_ff @(posedge clk) begin
        if (load) begin
            m_tdata        <= s_tdata;
            m_tkeep        <= s_tkeep;
            m_tlast        <= s_tlast;
            m_tuser_vendor <= s_tuser_vendor;
        end
    end

endmodule

// File: tb/tb_pcie_ss_axis_demux.sv
// Directed and scoreboarded random checks for the packet demux (3 channels, 32-bit data).
module tb_pcie_ss_axis_demux;

    localparam int NCH = 3;
    localparam int DW  = 32;
    localparam int UW  = 4;
    localparam int KW  = DW / 8;
    localparam int SW  = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           s_tvalid;
    logic           s_tready;
    logic [DW-1:0]  s_tdata;
    logic [KW-1:0]  s_tkeep;
    logic           s_tlast;
    logic [UW-1:0]  s_tuser_vendor;
    logic [SW-1:0]  s_tdest;
    logic [NCH-1:0] m_tvalid;
    logic [NCH-1:0] m_tready;
    logic [DW-1:0]  m_tdata;
    logic [KW-1:0]  m_tkeep;
    logic           m_tlast;
    logic [UW-1:0]  m_tuser_vendor;
    logic [15:0]    drop_cnt;
    logic           drop_pulse;

    logic [NCH-1:0] rdy_dir;
    logic [NCH-1:0] rdy_rnd;
    logic           rnd_rdy;
    assign m_tready = rnd_rdy ? rdy_rnd : rdy_dir;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [1:0]    ch;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    beat_t sbq[$];
    bit    sb_en = 1'b0;

    pcie_ss_axis_demux #(
        .NUM_CH(NCH),
        .TDATA_WIDTH(DW),
        .TUSER_WIDTH(UW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_tvalid(s_tvalid),
        .s_tready(s_tready),
        .s_tdata(s_tdata),
        .s_tkeep(s_tkeep),
        .s_tlast(s_tlast),
        .s_tuser_vendor(s_tuser_vendor),
        .s_tdest(s_tdest),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_tdata(m_tdata),
        .m_tkeep(m_tkeep),
        .m_tlast(m_tlast),
        .m_tuser_vendor(m_tuser_vendor),
        .drop_cnt(drop_cnt),
        .drop_pulse(drop_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rdy_rnd = NCH'($urandom);
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ch_of(input logic [NCH-1:0] v);
        case (v)
            3'b001:  return 2'd0;
            3'b010:  return 2'd1;
            3'b100:  return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [KW-1:0] keep_of(input logic [DW-1:0] d);
        return d[3:0] ^ 4'hA;
    endfunction

    function automatic logic [UW-1:0] user_of(input logic [DW-1:0] d);
        return d[7:4];
    endfunction

    // Inputs change at the falling edge; settle 1 time unit before looking at s_tready.
    task automatic drive(input logic v, input logic [1:0] d, input logic [DW-1:0] dat, input logic l);
        @(negedge clk);
        s_tvalid       = v;
        s_tdest        = d;
        s_tdata        = dat;
        s_tkeep        = keep_of(dat);
        s_tuser_vendor = user_of(dat);
        s_tlast        = l;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] d, input logic [DW-1:0] dat, input logic l);
        bit ok;
        ok = 1'b0;
        drive(1'b1, d, dat, l);
        for (int i = 0; i < 64 && !ok; i++) begin
            if (s_tready) ok = 1'b1;
            else begin
                @(negedge clk);
                #1;
            end
        end
        check("push_accept", 64'(ok), 64'd1);
        @(posedge clk);
    endtask

    // Output monitor: a beat is consumed at the next rising edge when valid & ready.
    always @(negedge clk) begin
        if (sb_en) begin
            check("onehot", 64'($countones(m_tvalid) <= 1), 64'd1);
            if ((m_tvalid & m_tready) != '0) begin
                beat_t obs;
                beat_t exp;
                obs = '{ch: ch_of(m_tvalid), data: m_tdata, keep: m_tkeep,
                        user: m_tuser_vendor, last: m_tlast};
                if (sbq.size() == 0) begin
                    check("sb_unexpected", 64'(obs), 64'h0);
                end else begin
                    exp = sbq.pop_front();
                    check("sb_beat", 64'(obs), 64'(exp));
                end
            end
        end
    end

    initial begin
        logic [1:0]    d;
        logic [1:0]    td;
        logic [DW-1:0] dat;
        int            n;

        rst = 1'b1;
        rnd_rdy = 1'b0;
        rdy_dir = 3'b111;
        s_tvalid = 1'b1;
        s_tdest = 2'd0;
        s_tdata = '0;
        s_tkeep = '0;
        s_tlast = 1'b0;
        s_tuser_vendor = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_tready", 64'(s_tready), 64'd0);
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("rst_drop_pulse", 64'(drop_pulse), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        s_tvalid = 1'b0;

        // 3-beat packet to channel 2; second run changes tdest on beats 2-3
        for (int run = 0; run < 2; run++) begin
            for (int b = 0; b < 3; b++) begin
                dat = 32'hA000_0000 + 32'(run * 16 + b);
                drive(1'b1, (b == 0) ? 2'd2 : ((run == 0) ? 2'd2 : 2'd1), dat, b == 2);
                check("pkt_s_tready", 64'(s_tready), 64'd1);
                tick();
                check("pkt_m_tvalid", 64'(m_tvalid), 64'b100);
                check("pkt_m_tdata", 64'(m_tdata), 64'(dat));
                check("pkt_m_tlast", 64'(m_tlast), 64'(b == 2));
                check("pkt_m_tkeep", 64'(m_tkeep), 64'(keep_of(dat)));
                check("pkt_m_tuser", 64'(m_tuser_vendor), 64'(user_of(dat)));
            end
            drive(1'b0, 2'd0, 32'h0, 1'b0);
            tick();
            check("pkt_idle_m_tvalid", 64'(m_tvalid), 64'd0);
        end

        // Drop packet: dest 3 on a 3-channel demux, 2 beats
        drive(1'b1, 2'd3, 32'hD0D0_0001, 1'b0);
        check("drop_b1_s_tready", 64'(s_tready), 64'd1);
        tick();
        check("drop_b1_m_tvalid", 64'(m_tvalid), 64'd0);
        check("drop_b1_pulse", 64'(drop_pulse), 64'd1);
        check("drop_b1_cnt", 64'(drop_cnt), 64'd1);
        drive(1'b1, 2'd0, 32'hD0D0_0002, 1'b1);
        check("drop_b2_s_tready", 64'(s_tready), 64'd1);
        tick();
        check("drop_b2_m_tvalid", 64'(m_tvalid), 64'd0);
        check("drop_b2_pulse", 64'(drop_pulse), 64'd0);
        check("drop_b2_cnt", 64'(drop_cnt), 64'd1);

        // Stall on channel 0, then release into back-to-back beats
        rdy_dir = 3'b110;
        drive(1'b1, 2'd0, 32'h5000_0000, 1'b1);
        check("stall_first_s_tready", 64'(s_tready), 64'd1);
        tick();
        drive(1'b1, 2'd0, 32'h5000_0001, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("stall_s_tready", 64'(s_tready), 64'd0);
            tick();
            check("stall_m_tvalid", 64'(m_tvalid), 64'b001);
            check("stall_m_tdata", 64'(m_tdata), 64'h5000_0000);
            @(negedge clk);
            #1;
        end
        rdy_dir = 3'b111;
        #1;
        check("release_s_tready", 64'(s_tready), 64'd1);
        for (int b = 1; b < 4; b++) begin
            if (b > 1) begin
                drive(1'b1, 2'd0, 32'h5000_0000 + 32'(b), 1'b1);
                check("b2b_s_tready", 64'(s_tready), 64'd1);
            end
            tick();
            check("b2b_m_tvalid", 64'(m_tvalid), 64'b001);
            check("b2b_m_tdata", 64'(m_tdata), 64'h5000_0000 + 64'(b));
        end
        drive(1'b0, 2'd0, 32'h0, 1'b0);
        tick();
        check("b2b_idle_m_tvalid", 64'(m_tvalid), 64'd0);

        // Reset in the middle of a 4-beat packet
        drive(1'b1, 2'd2, 32'h7000_0001, 1'b0);
        tick();
        check("rmid_b1_m_tvalid", 64'(m_tvalid), 64'b100);
        drive(1'b1, 2'd2, 32'h7000_0002, 1'b0);
        rst = 1'b1;
        #1;
        check("rmid_s_tready", 64'(s_tready), 64'd0);
        tick();
        check("rmid_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rmid_drop_cnt", 64'(drop_cnt), 64'd0);
        check("rmid_drop_pulse", 64'(drop_pulse), 64'd0);
        rst = 1'b0;
        drive(1'b1, 2'd1, 32'h7000_0003, 1'b1);
        check("rmid_sop_s_tready", 64'(s_tready), 64'd1);
        tick();
        check("rmid_sop_m_tvalid", 64'(m_tvalid), 64'b010);
        check("rmid_sop_m_tdata", 64'(m_tdata), 64'h7000_0003);
        check("rmid_sop_m_tlast", 64'(m_tlast), 64'd1);
        drive(1'b0, 2'd0, 32'h0, 1'b0);
        tick();
        check("rmid_idle_m_tvalid", 64'(m_tvalid), 64'd0);

        // Saturation: stream single-beat drop packets up to and past 16'hFFFF
        drive(1'b1, 2'd3, 32'h0, 1'b1);
        repeat (65534) @(posedge clk);
        #1;
        check("sat_cnt_fffe", 64'(drop_cnt), 64'hFFFE);
        check("sat_m_tvalid", 64'(m_tvalid), 64'd0);
        tick();
        check("sat_cnt_ffff", 64'(drop_cnt), 64'hFFFF);
        tick();
        check("sat_cnt_hold", 64'(drop_cnt), 64'hFFFF);
        check("sat_pulse", 64'(drop_pulse), 64'd1);
        drive(1'b0, 2'd0, 32'h0, 1'b0);
        tick();
        check("sat_pulse_clear", 64'(drop_pulse), 64'd0);
        check("sat_cnt_final", 64'(drop_cnt), 64'hFFFF);

        // Random packets, random destinations (3 = drop), random m_tready
        sb_en = 1'b1;
        rnd_rdy = 1'b1;
        for (int p = 0; p < 150; p++) begin
            n = $urandom_range(1, 4);
            d = 2'($urandom_range(0, 3));
            for (int b = 0; b < n; b++) begin
                dat = $urandom;
                td = (b == 0) ? d : 2'($urandom_range(0, 3));
                if (d != 2'd3) begin
                    sbq.push_back('{ch: d, data: dat, keep: keep_of(dat),
                                    user: user_of(dat), last: (b == n - 1)});
                end
                push(td, dat, b == n - 1);
            end
            if ($urandom_range(0, 3) == 0) drive(1'b0, 2'd0, 32'h0, 1'b0);
        end
        drive(1'b0, 2'd0, 32'h0, 1'b0);
        rnd_rdy = 1'b0;
        for (int i = 0; i < 50 && sbq.size() != 0; i++) tick();
        check("sb_drain", 64'(sbq.size()), 64'd0);
        sb_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
